altsyncram: RTL and testbench



---
 rtl/altsyncram_byte_lane.sv | 42 ++++
 rtl/altsyncram.sv | 90 +++++++++
 tb/tb_altsyncram.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/altsyncram_byte_lane.sv
// One byte-wide slice of the single-port RAM: its own storage array, write
// enable and registered read data. The top instantiates one per byte-enable lane.
module altsyncram_byte_lane #(
  parameter int byte_size  = 8,
  parameter int widthad_a  = 14,
  parameter int numwords_a = 16384
) (
  input  logic                 clock0,
  input  logic                 aclr0,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic                 i_valid,
  input  logic [widthad_a-1:0] i_addr,
  input  logic [byte_size-1:0] i_wdata,
  output logic [byte_size-1:0] o_rdata
);

  // NOTE: the storage array has no reset branch; clearing it would turn the
  // block RAM into a register file, so only the read register sees aclr0.
  logic [byte_size-1:0] r_mem [numwords_a] = '{default: '0};
  logic [byte_size-1:0] r_q = '0;

  always_ff @(posedge clock0) begin
    if (i_we) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the values from before the edge.
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Reset outranks a read; an out-of-range read loads zero.
  always_ff @(posedge clock0) begin
    if (aclr0) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= i_valid ? r_mem[i_addr] : '0;
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/altsyncram.sv
// Single-port synchronous RAM with byte enables and a one-cycle read, pin
// compatible with the vendor altsyncram primitive; port B pins are inert.
module altsyncram #(
  parameter int    width_a                      = 32,
  parameter int    widthad_a                    = 14,
  parameter int    numwords_a                   = 16384,
  parameter int    byte_size                    = 8,
  parameter int    width_byteena_a              = 4,
  parameter string init_file                    = "",
  parameter string operation_mode               = "SINGLE_PORT",
  parameter string outdata_reg_a                = "UNREGISTERED",
  parameter string clock_enable_input_a         = "NORMAL",
  parameter string clock_enable_output_a        = "BYPASS",
  parameter string read_during_write_mode_port_a = "DONT_CARE",
  parameter string power_up_uninitialized       = "FALSE",
  parameter string outdata_aclr_a               = "NONE",
  parameter string intended_device_family       = "",
  parameter string lpm_hint                     = "",
  parameter string lpm_type                     = "altsyncram"
) (
  input  logic                       clock0,
  input  logic                       aclr0,
  input  logic                       clocken0,
  input  logic [widthad_a-1:0]       address_a,
  input  logic [width_a-1:0]         data_a,
  input  logic [width_byteena_a-1:0] byteena_a,
  input  logic                       wren_a,
  input  logic                       rden_a,
  output logic [width_a-1:0]         q_a,
  input  logic                       aclr1,
  input  logic [widthad_a-1:0]       address_b,
  input  logic                       addressstall_a,
  input  logic                       addressstall_b,
  input  logic [width_byteena_a-1:0] byteena_b,
  input  logic                       clock1,
  input  logic                       clocken1,
  input  logic                       clocken2,
  input  logic                       clocken3,
  input  logic [width_a-1:0]         data_b,
  input  logic                       rden_b,
  input  logic                       wren_b,
  output logic [width_a-1:0]         q_b,
  output logic [2:0]                 eccstatus
);

  logic w_valid;
  logic w_wr;
  logic w_rd;

  assign w_valid = 32'(address_a) < 32'(numwords_a);
  assign w_wr    = clocken0 & wren_a & w_valid;
  // A simultaneous write suppresses the read, so q_a holds.
  assign w_rd    = clocken0 & rden_a & ~wren_a;

  for (genvar g = 0; g < width_byteena_a; g++) begin : g_lane
    altsyncram_byte_lane #(
      .byte_size (byte_size),
      .widthad_a (widthad_a),
      .numwords_a(numwords_a)
    ) u_lane (
      .clock0 (clock0),
      .aclr0  (aclr0),
      .i_we   (w_wr & byteena_a[g]),
      .i_re   (w_rd),
      .i_valid(w_valid),
      .i_addr (address_a),
      .i_wdata(data_a[g*byte_size +: byte_size]),
      .o_rdata(q_a[g*byte_size +: byte_size])
    );
  end

  assign q_b       = '0;
  assign eccstatus = '0;

  // Port B pins and the configuration strings exist only for drop-in compatibility.
  logic w_unused;
  assign w_unused = &{1'b0, aclr1, address_b, addressstall_a, addressstall_b,
                      byteena_b, clock1, clocken1, clocken2, clocken3, data_b,
                      rden_b, wren_b, (init_file == ""),
                      (operation_mode == "SINGLE_PORT"),
                      (outdata_reg_a == "UNREGISTERED"),
                      (clock_enable_input_a == "NORMAL"),
                      (clock_enable_output_a == "BYPASS"),
                      (read_during_write_mode_port_a == "DONT_CARE"),
                      (power_up_uninitialized == "FALSE"),
                      (outdata_aclr_a == "NONE"),
                      (intended_device_family == ""), (lpm_hint == ""),
                      (lpm_type == "")};

endmodule

// File: tb/tb_altsyncram.sv
// Self-checking bench for altsyncram: directed vector table, random traffic
// against a word-array model, and a small-depth instance for out-of-range addresses.
module tb_altsyncram;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance stimulus
  logic        aclr0, clocken0, wren_a, rden_a;
  logic [13:0] address_a;
  logic [31:0] data_a;
  logic [3:0]  byteena_a;
  logic [31:0] q_a, q_b;
  logic [2:0]  eccstatus;

  // Small instance (12 words, 4-bit address)
  logic        s_clr, s_en, s_wr, s_rd;
  logic [3:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_be;
  logic [31:0] s_q, s_qb;
  logic [2:0]  s_ecc;

  altsyncram dut (
    .clock0(clk), .aclr0(aclr0), .clocken0(clocken0), .address_a(address_a),
    .data_a(data_a), .byteena_a(byteena_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(q_a), .aclr1(1'b0), .address_b(14'h0), .addressstall_a(1'b0),
    .addressstall_b(1'b0), .byteena_b(4'h0), .clock1(1'b0), .clocken1(1'b0),
    .clocken2(1'b0), .clocken3(1'b0), .data_b(32'h0), .rden_b(1'b0),
    .wren_b(1'b0), .q_b(q_b), .eccstatus(eccstatus)
  );

  altsyncram #(.widthad_a(4), .numwords_a(12)) dut_s (
    .clock0(clk), .aclr0(s_clr), .clocken0(s_en), .address_a(s_addr),
    .data_a(s_data), .byteena_a(s_be), .wren_a(s_wr), .rden_a(s_rd),
    .q_a(s_q), .aclr1(1'b0), .address_b(4'h0), .addressstall_a(1'b0),
    .addressstall_b(1'b0), .byteena_b(4'h0), .clock1(1'b0), .clocken1(1'b0),
    .clocken2(1'b0), .clocken3(1'b0), .data_b(32'h0), .rden_b(1'b0),
    .wren_b(1'b0), .q_b(s_qb), .eccstatus(s_ecc)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference model: plain word array plus the last value read out.
  logic [31:0] m_mem [16384];
  logic [31:0] m_q;

  task automatic model_edge(input logic clr, en, wr, rd, input logic [13:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    logic [31:0] word;
    word = m_mem[a];
    if (clr) m_q = 32'h0;
    else if (en && rd && !wr) m_q = word;
    if (en && wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) word[8*b +: 8] = d[8*b +: 8];
      m_mem[a] = word;
    end
  endtask

  // Drive one edge on the full-size instance, keep the model in step.
  task automatic step(input logic clr, en, wr, rd, input logic [13:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    aclr0 = clr; clocken0 = en; wren_a = wr; rden_a = rd;
    address_a = a; data_a = d; byteena_a = be;
    model_edge(clr, en, wr, rd, a, d, be);
    @(posedge clk);
    #1;
  endtask

  task automatic s_step(input logic clr, en, wr, rd, input logic [3:0] a,
                        input logic [31:0] d);
    s_clr = clr; s_en = en; s_wr = wr; s_rd = rd; s_addr = a; s_data = d; s_be = 4'hF;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        clr, en, wr, rd;
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vt [20];

  initial begin
    for (int i = 0; i < 16384; i++) m_mem[i] = 32'h0;
    m_q = 32'h0;

    vt[0]  = '{"reset_edge",     1, 1, 0, 0, 14'h0005, 32'h0,        4'hF, 32'h0};
    vt[1]  = '{"write_full",     0, 1, 1, 0, 14'h0005, 32'h11223344, 4'hF, 32'h0};
    vt[2]  = '{"read_full",      0, 1, 0, 1, 14'h0005, 32'h0,        4'hF, 32'h11223344};
    vt[3]  = '{"write_be5",      0, 1, 1, 0, 14'h0005, 32'hAABBCCDD, 4'h5, 32'h11223344};
    vt[4]  = '{"read_be5",       0, 1, 0, 1, 14'h0005, 32'h0,        4'hF, 32'h11BB33DD};
    vt[5]  = '{"write_ce0",      0, 0, 1, 0, 14'h0005, 32'h0,        4'hF, 32'h11BB33DD};
    vt[6]  = '{"read_after_ce0", 0, 1, 0, 1, 14'h0005, 32'h0,        4'hF, 32'h11BB33DD};
    vt[7]  = '{"write_a6",       0, 1, 1, 0, 14'h0006, 32'h12345678, 4'hF, 32'h11BB33DD};
    vt[8]  = '{"read_ce0_hold",  0, 0, 0, 1, 14'h0006, 32'h0,        4'hF, 32'h11BB33DD};
    vt[9]  = '{"clr_over_read",  1, 1, 0, 1, 14'h0005, 32'h0,        4'hF, 32'h0};
    vt[10] = '{"read_after_clr", 0, 1, 0, 1, 14'h0005, 32'h0,        4'hF, 32'h11BB33DD};
    vt[11] = '{"write_top",      0, 1, 1, 0, 14'h3FFF, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD};
    vt[12] = '{"write_zero",     0, 1, 1, 0, 14'h0000, 32'h00000001, 4'hF, 32'h11BB33DD};
    vt[13] = '{"read_top",       0, 1, 0, 1, 14'h3FFF, 32'h0,        4'hF, 32'hFFFFFFFF};
    vt[14] = '{"read_zero",      0, 1, 0, 1, 14'h0000, 32'h0,        4'hF, 32'h00000001};
    vt[15] = '{"rd_wr_same",     0, 1, 1, 1, 14'h0000, 32'hCAFEF00D, 4'hF, 32'h00000001};
    vt[16] = '{"read_rdwr",      0, 1, 0, 1, 14'h0000, 32'h0,        4'hF, 32'hCAFEF00D};
    vt[17] = '{"clr_ce0",        1, 0, 0, 1, 14'h0000, 32'h0,        4'hF, 32'h0};
    vt[18] = '{"clr_with_write", 1, 1, 1, 0, 14'h0007, 32'h55AA55AA, 4'hF, 32'h0};
    vt[19] = '{"read_clr_write", 0, 1, 0, 1, 14'h0007, 32'h0,        4'hF, 32'h55AA55AA};

    aclr0 = 0; clocken0 = 0; wren_a = 0; rden_a = 0;
    address_a = '0; data_a = '0; byteena_a = '0;
    s_clr = 0; s_en = 0; s_wr = 0; s_rd = 0; s_addr = '0; s_data = '0; s_be = '0;
    @(negedge clk);
    check("power_up_q", q_a, 32'h0);
    check("q_b_zero", q_b, 32'h0);
    check("ecc_zero", {29'h0, eccstatus}, 32'h0);

    foreach (vt[i]) begin
      step(vt[i].clr, vt[i].en, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data, vt[i].be);
      check(vt[i].name, q_a, vt[i].exp_q);
    end

    // Out-of-range addresses on a 12-word instance
    s_step(0, 1, 1, 0, 4'd3,  32'h01020304);
    s_step(0, 1, 1, 0, 4'd13, 32'hDEADBEEF);
    s_step(0, 1, 0, 1, 4'd3,  32'h0);
    check("small_read_in", s_q, 32'h01020304);
    s_step(0, 1, 0, 1, 4'd13, 32'h0);
    check("small_read_oor", s_q, 32'h0);
    s_step(0, 1, 0, 1, 4'd3,  32'h0);
    check("small_reread", s_q, 32'h01020304);
    s_step(0, 1, 0, 1, 4'd12, 32'h0);
    check("small_read_12", s_q, 32'h0);

    // Random traffic over a handful of addresses so reads hit written data
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      a = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
      step($urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           a, $urandom, 4'($urandom));
      check("random", q_a, m_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
